// File: rtl/fifo_responder.sv
// Bus responder for the rq/ack/wr_ni protocol exposing a small FIFO, status and control in an address window.
// Optional head-peek register at offset 3 is enabled by defining FIFO_RESP_PEEK_EN.
module fifo_responder #(
  parameter int DATA_WIDTH           = 8,
  parameter int ADDR_WIDTH           = 4,
  parameter int ADDR_SPACE_BEGINNING = 4,
  parameter int ADDR_SPACE_END       = 7,
  parameter int DEPTH                = 8,
  parameter int DELAY_ACK            = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  rq,
  output logic                  ack,
  input  logic                  wr_ni,
  input  logic [DATA_WIDTH-1:0] dataW,
  output logic [DATA_WIDTH-1:0] dataR
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DLY_W = (DELAY_ACK > 1) ? $clog2(DELAY_ACK) : 1;

  localparam logic [DLY_W-1:0]      DLY_LAST = DLY_W'(DELAY_ACK - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WIN_LO   = ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
  localparam logic [ADDR_WIDTH-1:0] WIN_HI   = ADDR_WIDTH'(ADDR_SPACE_END);
  localparam logic [ADDR_WIDTH-1:0] OFF_FIFO = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OFF_STAT = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OFF_CTRL = ADDR_WIDTH'(2);
`ifdef FIFO_RESP_PEEK_EN
  localparam logic [ADDR_WIDTH-1:0] OFF_PEEK = ADDR_WIDTH'(3);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [DLY_W-1:0]        dly_r;
  logic [ADDR_WIDTH-1:0]   off_r;
  logic                    wr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    ack_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic                    unf_r;
  logic                    ovf_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  logic                    in_win_s;
  logic                    empty_s;
  logic                    full_s;
  logic                    access_s;
  logic                    push_s;
  logic [DATA_WIDTH-1:0]   status_s;
  logic [DATA_WIDTH-1:0]   rd_data_s;

  assign in_win_s = (address >= WIN_LO) && (address <= WIN_HI);
  assign empty_s  = (count_r == {CNT_W{1'b0}});
  assign full_s   = (count_r == CNT_FULL);
  assign status_s = {(DATA_WIDTH-4)'(count_r), ovf_r, unf_r, full_s, empty_s};
  // The access fires on the final WAIT edge, and only if the client is still requesting.
  assign access_s = (state_r == ST_WAIT) && rq && (dly_r == DLY_LAST);
  assign push_s   = access_s && wr_r && (off_r == OFF_FIFO) && !full_s;

  assign ack   = ack_r;
  assign dataR = data_r;

  // Read data for the pending access, based on pre-access state.
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    if (wr_r) begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      case (off_r)
        OFF_FIFO: rd_data_s = empty_s ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];
        OFF_STAT: rd_data_s = status_s;
`ifdef FIFO_RESP_PEEK_EN
        OFF_PEEK: rd_data_s = empty_s ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];
`endif
        default:  rd_data_s = {DATA_WIDTH{1'b0}};
      endcase
    end
  end

  // FIFO storage; an access coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      mem_r[wr_ptr_r] <= wdata_r;
    end
  end

  // Request FSM together with the FIFO bookkeeping it drives.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      dly_r    <= {DLY_W{1'b0}};
      off_r    <= {ADDR_WIDTH{1'b0}};
      wr_r     <= 1'b0;
      wdata_r  <= {DATA_WIDTH{1'b0}};
      ack_r    <= 1'b0;
      data_r   <= {DATA_WIDTH{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      unf_r    <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rq && in_win_s) begin
            state_r <= ST_WAIT;
            dly_r   <= {DLY_W{1'b0}};
            off_r   <= address - WIN_LO;
            wr_r    <= wr_ni;
            wdata_r <= dataW;
          end
        end
        ST_WAIT: begin
          if (!rq) begin
            state_r <= ST_IDLE;
          end else if (dly_r == DLY_LAST) begin
            state_r <= ST_ACK;
            ack_r   <= 1'b1;
            data_r  <= rd_data_s;
            case (off_r)
              OFF_FIFO: begin
                if (wr_r) begin
                  if (full_s) begin
                    ovf_r <= 1'b1;
                  end else begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                    count_r  <= count_r + CNT_W'(1);
                  end
                end else begin
                  if (empty_s) begin
                    unf_r <= 1'b1;
                  end else begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                    count_r  <= count_r - CNT_W'(1);
                  end
                end
              end
              OFF_STAT: begin
                if (!wr_r) begin
                  unf_r <= 1'b0;
                  ovf_r <= 1'b0;
                end
              end
              OFF_CTRL: begin
                if (wr_r && wdata_r[0]) begin
                  wr_ptr_r <= {PTR_W{1'b0}};
                  rd_ptr_r <= {PTR_W{1'b0}};
                  count_r  <= {CNT_W{1'b0}};
                  unf_r    <= 1'b0;
                  ovf_r    <= 1'b0;
                end
              end
              default: begin
              end
            endcase
          end else begin
            dly_r <= dly_r + DLY_W'(1);
          end
        end
        ST_ACK: begin
          if (!rq) begin
            state_r <= ST_IDLE;
            ack_r   <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
          data_r  <= {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_responder.sv
// Scoreboard bench for fifo_responder: the driver queues expected read data, a monitor checks it on each ack.
module tb_fifo_responder;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int DLY = 2;
  localparam int LAT = DLY + 1;  // negedges from driving rq to first seeing ack

  logic          clk;
  logic          reset;
  logic [AW-1:0] address;
  logic          rq;
  logic          ack;
  logic          wr_ni;
  logic [DW-1:0] dataW;
  logic [DW-1:0] dataR;

  int checks;
  int errors;
  logic [DW-1:0] exp_q[$];

  fifo_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_SPACE_BEGINNING(4),
    .ADDR_SPACE_END(7), .DEPTH(8), .DELAY_ACK(DLY)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .rq(rq), .ack(ack),
    .wr_ni(wr_ni), .dataW(dataW), .dataR(dataR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: on each rising ack pop the expected data; while ack holds, dataR must stay put.
  initial begin
    logic          ack_prev;
    logic [DW-1:0] held;
    logic [DW-1:0] e;
    ack_prev = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (ack === 1'b1 && ack_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("read_data", {24'd0, dataR}, {24'd0, e});
        end
        held = dataR;
      end else if (ack === 1'b1) begin
        check("data_stable", {24'd0, dataR}, {24'd0, held});
      end
      ack_prev = ack;
    end
  end

  task automatic req(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d,
                     input logic [DW-1:0] exp);
    int n;
    @(negedge clk);
    address = a; wr_ni = wr; dataW = d; rq = 1'b1;
    exp_q.push_back(wr ? 8'h00 : exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 40);
    check("ack_latency", n, LAT);
    @(negedge clk);
    rq = 1'b0;
    @(negedge clk);
    check("ack_fall", {31'd0, ack}, 32'd0);
    check("data_clear", {24'd0, dataR}, 32'd0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req(a, 1'b1, d, 8'h00);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    req(a, 1'b0, 8'h00, exp);
  endtask

  initial begin
    int n;
    logic seen;
    checks = 0; errors = 0;
    reset = 1'b0; rq = 1'b0; wr_ni = 1'b0; address = 4'd0; dataW = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_data", {24'd0, dataR}, 32'd0);
    reset = 1'b1;

    rd(4'd5, 8'h01);
    wr(4'd4, 8'hA1); wr(4'd4, 8'hB2); wr(4'd4, 8'hC3);
    rd(4'd4, 8'hA1); rd(4'd4, 8'hB2); rd(4'd4, 8'hC3);
    rd(4'd5, 8'h01);

    for (int i = 0; i < 9; i++) wr(4'd4, 8'h10 + 8'(i));
    rd(4'd5, 8'h8A);
    rd(4'd5, 8'h82);
    for (int i = 0; i < 8; i++) rd(4'd4, 8'h10 + 8'(i));
    rd(4'd5, 8'h01);

    rd(4'd4, 8'h00);
    rd(4'd5, 8'h05);
    rd(4'd5, 8'h01);

    wr(4'd4, 8'h01); wr(4'd4, 8'h02); wr(4'd4, 8'h03);
    wr(4'd6, 8'h01);
    rd(4'd5, 8'h01);
    rd(4'd6, 8'h00);

    // Out-of-window request held 20 cycles must never be acked.
    @(negedge clk);
    address = 4'd2; wr_ni = 1'b0; rq = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack === 1'b1) seen = 1'b1;
    end
    check("out_of_window_no_ack", {31'd0, seen}, 32'd0);
    rq = 1'b0;
    @(negedge clk);

    // Abort during WAIT: no ack and no pop.
    wr(4'd4, 8'h77);
    @(negedge clk);
    address = 4'd4; wr_ni = 1'b0; rq = 1'b1;
    @(negedge clk);
    rq = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack === 1'b1) seen = 1'b1;
    end
    check("abort_no_ack", {31'd0, seen}, 32'd0);
    rd(4'd5, 8'h10);
    rd(4'd4, 8'h77);

    wr(4'd4, 8'h5E);
`ifdef FIFO_RESP_PEEK_EN
    rd(4'd7, 8'h5E);
    rd(4'd7, 8'h5E);
`else
    rd(4'd7, 8'h00);
    rd(4'd7, 8'h00);
`endif
    rd(4'd5, 8'h10);
    rd(4'd4, 8'h5E);

    // Reset while ack is high discards everything.
    wr(4'd4, 8'h33); wr(4'd4, 8'h44);
    @(negedge clk);
    address = 4'd5; wr_ni = 1'b0; rq = 1'b1;
    exp_q.push_back(8'h20);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 40);
    check("ack_latency_pre_reset", n, LAT);
    reset = 1'b0; rq = 1'b0;
    @(negedge clk);
    check("reset_mid_ack", {31'd0, ack}, 32'd0);
    check("reset_mid_data", {24'd0, dataR}, 32'd0);
    reset = 1'b1;
    rd(4'd5, 8'h01);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
